// File: rtl/aes256_key_expansion_if.sv
// Control and data bundle for the AES-256 key-expansion block.
// S-box lane width follows KEYEXP_SBOX4_EN: 32 bits with four lanes, otherwise 8.
interface aes256_key_expansion_if;
`ifdef KEYEXP_SBOX4_EN
    localparam int SBOX_W = 32;
`else
    localparam int SBOX_W = 8;
`endif

    logic [255:0]      inp_keyExp;
    logic              start_keyExp;
    logic [SBOX_W-1:0] inp_sbox_keyExp;
    logic [SBOX_W-1:0] addr_sbox_keyExp;
    logic [127:0]      outp_keyExp;
    logic              wrEn_keyExp;
    logic              busy_keyExp;
    logic              done_keyExp;

    modport master (
        output inp_keyExp, start_keyExp, inp_sbox_keyExp,
        input  addr_sbox_keyExp, outp_keyExp, wrEn_keyExp, busy_keyExp, done_keyExp
    );

    modport slave (
        input  inp_keyExp, start_keyExp, inp_sbox_keyExp,
        output addr_sbox_keyExp, outp_keyExp, wrEn_keyExp, busy_keyExp, done_keyExp
    );
endinterface

// File: rtl/aes256_key_expansion.sv
// Iterative AES-256 key schedule emitting RK0..RK14, each with a one-cycle write strobe.
// KEYEXP_SBOX4_EN selects four parallel S-box lanes and a one-cycle SubWord.
module aes256_key_expansion (
    input logic clk,
    input logic reset,
    aes256_key_expansion_if.slave kx
);
    localparam int KEY_W = 256;
    localparam int RK_W  = 128;
    localparam int N_RK  = 15;
`ifdef KEYEXP_SBOX4_EN
    localparam int SBOX_W = 32;
`else
    localparam int SBOX_W = 8;
`endif

    typedef enum logic [2:0] {IDLE, EMIT0, EMIT1, SUB, EMIT, DONE} state_t;

    state_t           state;
    logic [0:7][31:0] win;
    logic [3:0]       k;
`ifndef KEYEXP_SBOX4_EN
    logic [1:0]       j;
    logic [23:0]      temp;
`endif
    logic [31:0]      sub_w;
    logic [31:0]      t_w;
    logic [0:3][31:0] n_w;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd2:    rcon = 8'h01;
            4'd4:    rcon = 8'h02;
            4'd6:    rcon = 8'h04;
            4'd8:    rcon = 8'h08;
            4'd10:   rcon = 8'h10;
            4'd12:   rcon = 8'h20;
            4'd14:   rcon = 8'h40;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Even rounds rotate the last word before substitution, odd rounds use it as is.
    function automatic logic [31:0] src_word(input logic [31:0] last, input logic [3:0] rnd);
        src_word = rnd[0] ? last : {last[23:0], last[31:24]};
    endfunction

    function automatic logic [SBOX_W-1:0] first_addr(input logic [31:0] last, input logic [3:0] rnd);
        logic [31:0] s;
        s = src_word(last, rnd);
        first_addr = s[31 -: SBOX_W];
    endfunction

`ifndef KEYEXP_SBOX4_EN
    function automatic logic [7:0] sub_byte(input logic [31:0] last, input logic [3:0] rnd,
                                            input logic [1:0] idx);
        logic [0:3][7:0] s;
        s = src_word(last, rnd);
        sub_byte = s[idx];
    endfunction
`endif

    // The last substituted byte (or all four lanes) is taken straight from the S-box.
    always_comb begin
`ifdef KEYEXP_SBOX4_EN
        sub_w = kx.inp_sbox_keyExp;
`else
        sub_w = {temp, kx.inp_sbox_keyExp};
`endif
        t_w    = k[0] ? sub_w : (sub_w ^ {rcon(k), 24'h000000});
        n_w[0] = win[0] ^ t_w;
        n_w[1] = win[1] ^ n_w[0];
        n_w[2] = win[2] ^ n_w[1];
        n_w[3] = win[3] ^ n_w[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            win                 <= '0;
            k                   <= '0;
`ifndef KEYEXP_SBOX4_EN
            j                   <= '0;
            temp                <= '0;
`endif
            kx.outp_keyExp      <= '0;
            kx.wrEn_keyExp      <= 1'b0;
            kx.busy_keyExp      <= 1'b0;
            kx.done_keyExp      <= 1'b0;
            kx.addr_sbox_keyExp <= '0;
        end else begin
            kx.wrEn_keyExp <= 1'b0;
            kx.done_keyExp <= 1'b0;
            case (state)
                IDLE: begin
                    if (kx.start_keyExp) begin
                        win            <= kx.inp_keyExp;
                        k              <= 4'd2;
                        kx.outp_keyExp <= kx.inp_keyExp[KEY_W-1 -: RK_W];
                        kx.wrEn_keyExp <= 1'b1;
                        kx.busy_keyExp <= 1'b1;
                        state          <= EMIT0;
                    end
                end
                EMIT0: begin
                    kx.outp_keyExp <= win[4:7];
                    kx.wrEn_keyExp <= 1'b1;
                    state          <= EMIT1;
                end
                EMIT1: begin
                    kx.addr_sbox_keyExp <= first_addr(win[7], k);
`ifndef KEYEXP_SBOX4_EN
                    j                   <= 2'd0;
`endif
                    state               <= SUB;
                end
                SUB: begin
`ifdef KEYEXP_SBOX4_EN
                    kx.outp_keyExp      <= n_w;
                    kx.wrEn_keyExp      <= 1'b1;
                    win                 <= {win[4:7], n_w};
                    kx.addr_sbox_keyExp <= '0;
                    state               <= EMIT;
`else
                    if (j == 2'd3) begin
                        kx.outp_keyExp      <= n_w;
                        kx.wrEn_keyExp      <= 1'b1;
                        win                 <= {win[4:7], n_w};
                        kx.addr_sbox_keyExp <= '0;
                        state               <= EMIT;
                    end else begin
                        temp                <= {temp[15:0], kx.inp_sbox_keyExp};
                        j                   <= j + 2'd1;
                        kx.addr_sbox_keyExp <= sub_byte(win[7], k, j + 2'd1);
                    end
`endif
                end
                EMIT: begin
                    if (k == 4'(N_RK - 1)) begin
                        kx.done_keyExp <= 1'b1;
                        kx.busy_keyExp <= 1'b0;
                        state          <= DONE;
                    end else begin
                        k                   <= k + 4'd1;
                        kx.addr_sbox_keyExp <= first_addr(win[7], k + 4'd1);
`ifndef KEYEXP_SBOX4_EN
                        j                   <= 2'd0;
`endif
                        state               <= SUB;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes256_key_expansion.sv
// Scoreboard bench for aes256_key_expansion: a word-level FIPS-197 schedule predicts every
// round key and its cycle, and a negedge monitor pops and compares each strobe and done pulse.
module tb_aes256_key_expansion;
    typedef struct {
        int           cyc;
        logic [127:0] rk;
    } exp_t;

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    bit           mon_en = 1'b0;
    logic [7:0]   sbox_tab [256];
    exp_t         exp_q[$];
    int           done_q[$];
    logic [127:0] last_out = '0;
    exp_t         mon_e;
    int           mon_d;

    aes256_key_expansion_if bus ();

    aes256_key_expansion dut (
        .clk   (clk),
        .reset (reset),
        .kx    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef KEYEXP_SBOX4_EN
    always_comb begin
        for (int i = 0; i < 4; i++)
            bus.inp_sbox_keyExp[8*i +: 8] = sbox_tab[bus.addr_sbox_keyExp[8*i +: 8]];
    end
`else
    assign bus.inp_sbox_keyExp = sbox_tab[bus.addr_sbox_keyExp];
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [127:0] model_rk(input logic [255:0] key, input int r);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // Published vectors take precedence over the model where they exist.
    function automatic logic [127:0] exp_rk(input logic [255:0] key, input int r);
        if (key == KEY_A3 && r == 0)  return 128'h603deb1015ca71be2b73aef0857d7781;
        if (key == KEY_A3 && r == 2)  return 128'h9ba354118e6925afa51a8b5f2067fcde;
        if (key == KEY_A3 && r == 14) return 128'hfe4890d1e6188d0b046df344706c631e;
        if (key == '0 && r < 2)       return '0;
        if (key == '0 && r == 2)      return 128'h62636363626363636263636362636363;
        return model_rk(key, r);
    endfunction

    function automatic int rk_cyc(input int r);
`ifdef KEYEXP_SBOX4_EN
        return (r < 2) ? r + 1 : 2 * r;
`else
        return (r < 2) ? r + 1 : 5 * r - 3;
`endif
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic issue_start(input logic [255:0] key, output int s);
        exp_t e;
        bus.inp_keyExp   = key;
        bus.start_keyExp = 1'b1;
        s = cyc;
        for (int r = 0; r < 15; r++) begin
            e.cyc = s + rk_cyc(r);
            e.rk  = exp_rk(key, r);
            exp_q.push_back(e);
        end
        done_q.push_back(s + rk_cyc(14) + 1);
        @(posedge clk); #1;
        bus.start_keyExp = 1'b0;
    endtask

    task automatic pulse_start(input logic [255:0] key);
        bus.inp_keyExp   = key;
        bus.start_keyExp = 1'b1;
        @(posedge clk); #1;
        bus.start_keyExp = 1'b0;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("run_drained", 128'(exp_q.size() + done_q.size()), 128'd0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_busy"}, 128'(bus.busy_keyExp), 128'd0);
        check({tag, "_wrEn"}, 128'(bus.wrEn_keyExp), 128'd0);
        check({tag, "_done"}, 128'(bus.done_keyExp), 128'd0);
        check({tag, "_addr"}, 128'(bus.addr_sbox_keyExp), 128'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.wrEn_keyExp) begin
                check("strobe_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rk_value", bus.outp_keyExp, mon_e.rk);
                    check("rk_cycle", 128'(cyc), 128'(mon_e.cyc));
                    check("busy_at_strobe", 128'(bus.busy_keyExp), 128'd1);
                    check("addr_at_strobe", 128'(bus.addr_sbox_keyExp), 128'd0);
                end
                last_out = bus.outp_keyExp;
            end else begin
                check("outp_hold", bus.outp_keyExp, last_out);
            end
            if (bus.done_keyExp) begin
                check("done_expected", 128'(done_q.size() != 0), 128'd1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", 128'(cyc), 128'(mon_d));
                    check("busy_at_done", 128'(bus.busy_keyExp), 128'd0);
                end
            end
            if (reset) last_out = '0;
        end
    end

    initial begin
        int s;
        build_sbox();
        bus.inp_keyExp   = '0;
        bus.start_keyExp = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_outp", bus.outp_keyExp, 128'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        check_quiet("reset_state");

        // A.3 key, with stray starts and a key change mid-run and in the done cycle.
        issue_start(KEY_A3, s);
        go_to(s + 10);
        pulse_start(rand_key());
        go_to(s + rk_cyc(14) + 1);
        pulse_start(rand_key());
        wait_idle(200);
        repeat (5) begin @(posedge clk); #1; end
        check_quiet("after_repulse");

        // Back-to-back: second start lands on the first cycle after done.
        issue_start(KEY_A3, s);
        wait_idle(200);
        check("b2b_restart_cycle", 128'(cyc - s), 128'(rk_cyc(14) + 2));
        issue_start('0, s);
        wait_idle(200);

        // Reset mid-expansion, then a clean restart two cycles later.
        issue_start(KEY_A3, s);
        go_to(s + 30);
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_outp", bus.outp_keyExp, 128'd0);
        check("abort_busy", 128'(bus.busy_keyExp), 128'd0);
        check("abort_wrEn", 128'(bus.wrEn_keyExp), 128'd0);
        @(posedge clk); #1;
        issue_start(KEY_A3, s);
        wait_idle(200);

        // Reset and start together: reset wins, no expansion starts.
        bus.inp_keyExp   = rand_key();
        bus.start_keyExp = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start_keyExp = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check_quiet("reset_with_start");

        for (int n = 0; n < 3; n++) begin
            issue_start(rand_key(), s);
            wait_idle(200);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (4) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
